// File: rtl/gray_host.sv
// Gray image host: loads one IMG_W x IMG_H raster image of 8-bit pixels, then serves
// same-cycle random reads to an LBP engine until it reports completion.
module gray_host #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DEPTH = IMG_W * IMG_H,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic          gray_ready,
  output logic [7:0]    gray_data,
  input  logic          finish,
  output logic          done,
  output logic [14:0]   req_cnt,
  output logic          proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [14:0]   CNT_MAX   = 15'h7FFF;

  state_t        state_r;
  state_t        next_state_s;
  logic [AW-1:0] wr_ptr_r;
  logic [7:0]    mem [0:DEPTH-1];
  logic          wr_en_s;
  logic          serve_req_s;

  assign wr_en_s     = (state_r == LOAD) && load_valid;
  assign serve_req_s = (state_r == SERVE) && gray_req;

  // Next-state decode; DONE only leaves through reset.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = LOAD;
        else       next_state_s = IDLE;
      end
      LOAD: begin
        if (wr_en_s && (wr_ptr_r == LAST_ADDR)) next_state_s = SERVE;
        else                                    next_state_s = LOAD;
      end
      SERVE: begin
        if (finish) next_state_s = DONE;
        else        next_state_s = SERVE;
      end
      DONE:    next_state_s = DONE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, pointer, counters and status flags; status outputs are decoded from next state
  // so they line up with the registered state without extra delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      wr_ptr_r   <= '0;
      load_ready <= 1'b0;
      gray_ready <= 1'b0;
      done       <= 1'b0;
      req_cnt    <= 15'd0;
      proto_err  <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      load_ready <= (next_state_s == LOAD);
      gray_ready <= (next_state_s == SERVE);
      done       <= (next_state_s == DONE);
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (serve_req_s && (req_cnt != CNT_MAX)) begin
        req_cnt <= req_cnt + 15'd1;
      end
      if (gray_req && (state_r != SERVE)) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Pixel storage is deliberately left out of reset so an image survives DONE.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_r] <= load_data;
    end
  end

  // Same-cycle read port, forced to zero whenever no legal request is being served.
  always_comb begin
    gray_data = 8'h00;
    if (serve_req_s) begin
      gray_data = mem[gray_addr];
    end else begin
      gray_data = 8'h00;
    end
  end

endmodule

// File: tb/tb_gray_host.sv
// Directed self-checking bench for gray_host: load with and without bubbles, serving,
// protocol errors, completion and asynchronous reset mid-load.
module tb_gray_host;

  localparam int DEPTH = 16384;

  logic        clk;
  logic        reset;
  logic        start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic        gray_ready;
  logic [7:0]  gray_data;
  logic        finish;
  logic        done;
  logic [14:0] req_cnt;
  logic        proto_err;

  int checks;
  int errors;

  gray_host #(.IMG_W(128), .IMG_H(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_ready (gray_ready),
    .gray_data  (gray_data),
    .finish     (finish),
    .done       (done),
    .req_cnt    (req_cnt),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_load_ready"}, {31'd0, load_ready}, 32'd0);
    check({tag, "_gray_ready"}, {31'd0, gray_ready}, 32'd0);
    check({tag, "_gray_data"},  {24'd0, gray_data},  32'd0);
    check({tag, "_done"},       {31'd0, done},       32'd0);
    check({tag, "_req_cnt"},    {17'd0, req_cnt},    32'd0);
    check({tag, "_proto_err"},  {31'd0, proto_err},  32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] half;
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    start      = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    gray_req   = 1'b0;
    gray_addr  = 14'd0;
    finish     = 1'b0;
    tick();
    tick();
    check_reset_values("por");
    reset = 1'b0;
    tick();

    // Session A: continuous load with one illegal request in the middle of it.
    pulse_start();
    check("a_load_ready_after_start", {31'd0, load_ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1'b1;
      load_data  = i[7:0];
      gray_req   = (i == 10);
      gray_addr  = 14'd5;
      if (i == 10) begin
        #1;
        check("a_gray_data_in_load", {24'd0, gray_data}, 32'd0);
      end
      if (i == DEPTH - 1) begin
        check("a_gray_ready_before_last", {31'd0, gray_ready}, 32'd0);
        check("a_load_ready_before_last", {31'd0, load_ready}, 32'd1);
      end
      tick();
    end
    load_valid = 1'b0;
    gray_req   = 1'b0;
    check("a_load_ready_after_last", {31'd0, load_ready}, 32'd0);
    check("a_gray_ready_after_last", {31'd0, gray_ready}, 32'd1);
    check("a_proto_err_sticky",      {31'd0, proto_err},  32'd1);
    check("a_req_cnt_zero",          {17'd0, req_cnt},    32'd0);

    gray_req  = 1'b1;
    gray_addr = 14'd129;
    #1;
    check("a_gray_data_129", {24'd0, gray_data}, 32'h81);
    tick();
    check("a_req_cnt_1", {17'd0, req_cnt}, 32'd1);
    gray_req = 1'b0;
    #1;
    check("a_gray_data_idle_req", {24'd0, gray_data}, 32'd0);
    tick();
    check("a_req_cnt_hold", {17'd0, req_cnt}, 32'd1);
    gray_req  = 1'b1;
    gray_addr = 14'd300;
    #1;
    check("a_gray_data_300", {24'd0, gray_data}, 32'h2C);
    gray_addr = 14'd16383;
    #1;
    check("a_gray_data_16383", {24'd0, gray_data}, 32'hFF);
    tick();
    check("a_req_cnt_2", {17'd0, req_cnt}, 32'd2);

    finish    = 1'b1;
    gray_addr = 14'd511;
    #1;
    check("a_gray_data_finish", {24'd0, gray_data}, 32'hFF);
    tick();
    finish   = 1'b0;
    gray_req = 1'b0;
    check("a_req_cnt_finish", {17'd0, req_cnt},    32'd3);
    check("a_done",           {31'd0, done},       32'd1);
    check("a_gray_ready_done",{31'd0, gray_ready}, 32'd0);
    start      = 1'b1;
    load_valid = 1'b1;
    tick();
    tick();
    start      = 1'b0;
    load_valid = 1'b0;
    check("a_done_holds",       {31'd0, done},       32'd1);
    check("a_load_ready_done",  {31'd0, load_ready}, 32'd0);
    check("a_gray_ready_held",  {31'd0, gray_ready}, 32'd0);

    // Asynchronous reset out of DONE, then finish in IDLE must be ignored.
    reset = 1'b1;
    #1;
    check_reset_values("rst_done");
    tick();
    reset  = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    check("b_finish_idle_load_ready", {31'd0, load_ready}, 32'd0);
    check("b_finish_idle_done",       {31'd0, done},       32'd0);
    check("b_finish_idle_proto",      {31'd0, proto_err},  32'd0);

    // Session B: load_valid alternates 1,0,... so 16384 bytes take 32767 cycles.
    pulse_start();
    for (int c = 0; c < 2 * DEPTH - 1; c++) begin
      half       = c / 2;
      load_valid = (c % 2 == 0);
      load_data  = half[7:0];
      if (c == 2 * DEPTH - 2) begin
        check("b_gray_ready_before_last", {31'd0, gray_ready}, 32'd0);
      end
      tick();
    end
    load_valid = 1'b0;
    check("b_gray_ready_after_last", {31'd0, gray_ready}, 32'd1);
    check("b_load_ready_after_last", {31'd0, load_ready}, 32'd0);
    check("b_proto_err_clear",       {31'd0, proto_err},  32'd0);
    gray_req  = 1'b1;
    gray_addr = 14'd300;
    #1;
    check("b_gray_data_300", {24'd0, gray_data}, 32'h2C);
    gray_addr = 14'd129;
    #1;
    check("b_gray_data_129", {24'd0, gray_data}, 32'h81);
    gray_addr = 14'h1234;
    #1;
    check("b_gray_data_1234", {24'd0, gray_data}, 32'h34);
    tick();
    gray_req = 1'b0;
    check("b_req_cnt_1", {17'd0, req_cnt}, 32'd1);

    // Session C: reset after 5000 bytes, then a full reload with a different pattern.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulse_start();
    for (int i = 0; i < 5000; i++) begin
      load_valid = 1'b1;
      load_data  = i[7:0] ^ 8'hFF;
      tick();
    end
    reset = 1'b1;
    #1;
    check_reset_values("rst_mid_load");
    load_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("c_idle_gray_ready", {31'd0, gray_ready}, 32'd0);
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1'b1;
      load_data  = i[7:0] ^ 8'h5A;
      if (i == DEPTH - 1) begin
        check("c_gray_ready_before_last", {31'd0, gray_ready}, 32'd0);
      end
      tick();
    end
    load_valid = 1'b0;
    check("c_gray_ready_after_last", {31'd0, gray_ready}, 32'd1);
    gray_req  = 1'b1;
    gray_addr = 14'd300;
    #1;
    check("c_gray_data_300", {24'd0, gray_data}, 32'h76);
    gray_addr = 14'd4999;
    #1;
    check("c_gray_data_4999", {24'd0, gray_data}, 32'hDD);
    tick();
    gray_req = 1'b0;
    check("c_req_cnt_1", {17'd0, req_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
